// File: rtl/l1_mmu_arbiter.sv
// ---------------------------------------------------------------------------
// l1_mmu_arbiter
// N-channel arbiter between the L1 caches and the single l1mmu port.
// One full-line transaction per grant. Command, address and write line are
// latched at grant. The completion pulse is routed back to the owner only.
// Optional feature macro: L1ARB_ROUND_ROBIN_EN. When defined, selection is
// round-robin; otherwise fixed priority, where channel 0 (iCache) wins.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module l1_mmu_arbiter #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int GNT_W  = $clog2(N_CH)
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          l1_req_read,
   input  logic [N_CH-1:0]          l1_req_write,
   input  logic [N_CH*ADDR_W-1:0]   l1_req_addr,
   input  logic [N_CH*LINE_W-1:0]   l1_write_data,
   output logic [N_CH-1:0]          l1_done,
   output logic [LINE_W-1:0]        l1_read_data,
   output logic                     mmu_req_read,
   output logic                     mmu_req_write,
   output logic [ADDR_W-1:0]        mmu_req_addr,
   output logic [LINE_W-1:0]        mmu_write_data,
   input  logic                     mmu_done,
   input  logic [LINE_W-1:0]        mmu_read_data,
   output logic                     busy,
   output logic [GNT_W-1:0]         gnt_id
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [N_CH-1:0]   req;
   logic              any_req;
   logic              grant;
   logic [GNT_W-1:0]  winner;

   assign req     = l1_req_read | l1_req_write;
   assign any_req = |req;
   assign grant   = (state == IDLE) && any_req;

`ifdef L1ARB_ROUND_ROBIN_EN
   logic [GNT_W-1:0] rr_ptr;

   // Round-robin pick: scan from the farthest offset down so the channel
   // nearest after the pointer is the last one assigned and therefore wins.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      for (int k = N_CH; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % N_CH;
         if (req[idx]) begin
            winner = GNT_W'(idx);
         end
      end
   end

   // Pointer follows the most recent winner; reset puts channel 0 first in line.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= GNT_W'(N_CH - 1);
      end else if (grant) begin
         rr_ptr <= winner;
      end
   end
`else
   // Fixed priority pick: scan from the top so the lowest requesting index wins.
   always_comb begin
      winner = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (req[k]) begin
            winner = GNT_W'(k);
         end
      end
   end
`endif

   // State register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: grant out of IDLE, return to IDLE on downstream completion.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)  state_nxt = BUSY;
         BUSY:    if (mmu_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Downstream payload: latched at grant and held for the whole transaction.
   // Only the command bits clear on completion; the address and line linger.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         mmu_req_read   <= 1'b0;
         mmu_req_write  <= 1'b0;
         mmu_req_addr   <= '0;
         mmu_write_data <= '0;
         gnt_id         <= '0;
      end else if (grant) begin
         mmu_req_read   <= l1_req_read[winner];
         mmu_req_write  <= l1_req_write[winner];
         mmu_req_addr   <= l1_req_addr[int'(winner)*ADDR_W +: ADDR_W];
         mmu_write_data <= l1_write_data[int'(winner)*LINE_W +: LINE_W];
         gnt_id         <= winner;
      end else if ((state == BUSY) && mmu_done) begin
         mmu_req_read   <= 1'b0;
         mmu_req_write  <= 1'b0;
      end
   end

   // Completion pulse goes to the owner only, in the same cycle as mmu_done.
   always_comb begin
      l1_done = '0;
      if ((state == BUSY) && mmu_done) begin
         l1_done[gnt_id] = 1'b1;
      end
   end

   assign busy         = (state == BUSY);
   assign l1_read_data = mmu_read_data;

endmodule

`default_nettype wire

// File: tb/tb_l1_mmu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1_mmu_arbiter
// Directed and randomized bench for l1_mmu_arbiter with three channels.
// Follows L1ARB_ROUND_ROBIN_EN the same way the design does.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_l1_mmu_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int LW = 256;
   localparam int GW = 2;

   logic              sys_clk = 1'b0;
   logic              rst;
   logic [N-1:0]      l1_req_read;
   logic [N-1:0]      l1_req_write;
   logic [N*AW-1:0]   l1_req_addr;
   logic [N*LW-1:0]   l1_write_data;
   logic [N-1:0]      l1_done;
   logic [LW-1:0]     l1_read_data;
   logic              mmu_req_read;
   logic              mmu_req_write;
   logic [AW-1:0]     mmu_req_addr;
   logic [LW-1:0]     mmu_write_data;
   logic              mmu_done;
   logic [LW-1:0]     mmu_read_data;
   logic              busy;
   logic [GW-1:0]     gnt_id;

   int checks   = 0;
   int failures = 0;

   // Reference model state: the transaction the arbiter should currently own.
   logic              m_busy;
   logic [GW-1:0]     m_gnt;
   int                m_ptr;
   logic              m_rd;
   logic              m_wr;
   logic [AW-1:0]     m_addr;
   logic [LW-1:0]     m_data;

   int                exp_order [5];

   l1_mmu_arbiter #(.N_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
      .sys_clk        (sys_clk),
      .rst            (rst),
      .l1_req_read    (l1_req_read),
      .l1_req_write   (l1_req_write),
      .l1_req_addr    (l1_req_addr),
      .l1_write_data  (l1_write_data),
      .l1_done        (l1_done),
      .l1_read_data   (l1_read_data),
      .mmu_req_read   (mmu_req_read),
      .mmu_req_write  (mmu_req_write),
      .mmu_req_addr   (mmu_req_addr),
      .mmu_write_data (mmu_write_data),
      .mmu_done       (mmu_done),
      .mmu_read_data  (mmu_read_data),
      .busy           (busy),
      .gnt_id         (gnt_id)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("comparison %s did not hold", tag);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_gnt  = '0;
      m_ptr  = N - 1;
      m_rd   = 1'b0;
      m_wr   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   // Which channel the rules say should win, or -1 when nobody asks.
   function automatic int pick(input logic [N-1:0] r);
`ifdef L1ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
`else
      for (int i = 0; i < N; i++) begin
         if (r[i]) return i;
      end
`endif
      return -1;
   endfunction

   // One cycle: inputs were set at this falling edge; compare all outputs,
   // then advance the model to what the coming rising edge should produce.
   task automatic tick();
      logic [N-1:0] e_done;
      int           w;
      #1;
      if (rst) model_reset();
      e_done = '0;
      if (m_busy && mmu_done) e_done[m_gnt] = 1'b1;
      chk("l1_done",        LW'(l1_done),        LW'(e_done));
      chk("l1_read_data",   l1_read_data,        mmu_read_data);
      chk("busy",           LW'(busy),           LW'(m_busy));
      chk("mmu_req_read",   LW'(mmu_req_read),   LW'(m_rd));
      chk("mmu_req_write",  LW'(mmu_req_write),  LW'(m_wr));
      chk("gnt_id",         LW'(gnt_id),         LW'(m_gnt));
      chk("mmu_req_addr",   LW'(mmu_req_addr),   LW'(m_addr));
      chk("mmu_write_data", mmu_write_data,      m_data);
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         w = pick(l1_req_read | l1_req_write);
         if (w >= 0) begin
            m_busy = 1'b1;
            m_gnt  = GW'(w);
            m_ptr  = w;
            m_rd   = l1_req_read[w];
            m_wr   = l1_req_write[w];
            m_addr = l1_req_addr[w*AW +: AW];
            m_data = l1_write_data[w*LW +: LW];
         end
      end else if (mmu_done) begin
         m_busy = 1'b0;
         m_rd   = 1'b0;
         m_wr   = 1'b0;
      end
      @(negedge sys_clk);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic rand_payload();
      for (int c = 0; c < N; c++) begin
         l1_req_addr[c*AW +: AW]   = $urandom;
         l1_write_data[c*LW +: LW] = rand_line();
      end
      mmu_read_data = rand_line();
   endtask

   initial begin
`ifdef L1ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 2, 0, 1};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif
      model_reset();
      rst           = 1'b1;
      l1_req_read   = '0;
      l1_req_write  = '0;
      l1_req_addr   = '0;
      l1_write_data = '0;
      mmu_done      = 1'b0;
      mmu_read_data = '0;
      @(negedge sys_clk);
      @(negedge sys_clk);

      // Reset state, then release.
      tick();
      rst = 1'b0;
      tick();

      // Spurious completion while idle must not produce a pulse or a state change.
      mmu_done      = 1'b1;
      mmu_read_data = rand_line();
      tick();
      tick();
      mmu_done = 1'b0;

      // Single read on channel 1, completion three cycles after grant.
      l1_req_read           = 3'b010;
      l1_req_addr[1*AW +: AW] = 32'h0000_1040;
      tick();
      #1 chk("single_addr", LW'(mmu_req_addr), LW'(32'h0000_1040));
      tick();
      tick();
      mmu_done      = 1'b1;
      mmu_read_data = {8{32'hA5A5_0001}};
      #1 chk("single_done", LW'(l1_done), LW'(3'b010));
      chk("single_data", l1_read_data, {8{32'hA5A5_0001}});
      tick();
      mmu_done    = 1'b0;
      l1_req_read = '0;
      #1 chk("single_idle_after", LW'(busy), LW'(1'b0));
      tick();

      // Write on channel 2; the requester scribbles its lines while busy.
      l1_req_write              = 3'b100;
      l1_req_addr[2*AW +: AW]   = 32'h8000_0020;
      l1_write_data[2*LW +: LW] = {8{32'hDEAD_BEEF}};
      tick();
      l1_req_addr[2*AW +: AW]   = 32'h1234_5678;
      l1_write_data[2*LW +: LW] = rand_line();
      tick();
      #1 chk("wr_hold_addr", LW'(mmu_req_addr), LW'(32'h8000_0020));
      chk("wr_hold_data", mmu_write_data, {8{32'hDEAD_BEEF}});
      mmu_done = 1'b1;
      tick();
      mmu_done     = 1'b0;
      l1_req_write = '0;
      tick();

      // Reset one cycle after a grant abandons the transaction at once.
      l1_req_read = 3'b010;
      tick();
      rst      = 1'b1;
      mmu_done = 1'b1;
      #1 chk("rst_mid_read", LW'(mmu_req_read), LW'(1'b0));
      chk("rst_mid_busy", LW'(busy), LW'(1'b0));
      chk("rst_mid_done", LW'(l1_done), LW'(3'b000));
      tick();
      mmu_done = 1'b0;
      tick();

      // All channels request continuously; completion two cycles after grant.
      rst         = 1'b0;
      l1_req_read = 3'b111;
      for (int g = 0; g < 5; g++) begin
         tick();
         #1 chk("grant_order", LW'(gnt_id), LW'(exp_order[g]));
         tick();
         mmu_done = 1'b1;
         tick();
         mmu_done = 1'b0;
      end
      l1_req_read = '0;
      tick();

      // Randomized traffic, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         l1_req_read  = 3'($urandom) & 3'($urandom);
         l1_req_write = 3'($urandom) & 3'($urandom) & 3'($urandom);
         mmu_done     = ($urandom_range(0, 2) == 0);
         rst          = ($urandom_range(0, 79) == 0);
         rand_payload();
         tick();
      end
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/l1_mmu_arbiter.md
# l1_mmu_arbiter

Parametrised N-channel arbiter between the L1 caches (iCache, dCache, and future requesters) and the single `l1mmu` port. It replaces the fixed iCache-priority combinational mux in the top level. Each transaction is a full 256-bit line read or write and is owned by exactly one channel from grant to `mmu_done`. Command, address and write data are latched at grant, and the completion pulse is routed back to the owning channel only.

## Interface
Parameters:
- `N_CH`, 2, number of requester channels (legal 2..8); channel 0 is the iCache, channel 1 the dCache.
- `ADDR_W`, 32, address width.
- `LINE_W`, 256, line width in bits.
- `GNT_W`, `$clog2(N_CH)`, width of the grant index (derived; do not override).

Ports:
- `sys_clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `l1_req_read` in N_CH: per-channel line-read request.
- `l1_req_write` in N_CH: per-channel line-write request.
- `l1_req_addr` in N_CH*ADDR_W: packed addresses; channel i occupies `[i*ADDR_W +: ADDR_W]`.
- `l1_write_data` in N_CH*LINE_W: packed write lines, same packing as the addresses.
- `l1_done` out N_CH: one-hot completion pulse.
- `l1_read_data` out LINE_W: shared read line, valid only while the owner's `l1_done` bit is high.
- `mmu_req_read`, `mmu_req_write` out 1: downstream command.
- `mmu_req_addr` out ADDR_W; `mmu_write_data` out LINE_W: latched downstream payload.
- `mmu_done` in 1; `mmu_read_data` in LINE_W: downstream completion and read line.
- `busy` out 1: a transaction is in flight.
- `gnt_id` out GNT_W: index of the current or most recent owner.

## Operation
- FSM with two states:
  - IDLE: evaluate requests.
  - BUSY: a transaction is outstanding.
- A channel is *requesting* when `l1_req_read[i] | l1_req_write[i]`.
- IDLE with at least one requesting channel:
  - Select a winner.
  - Latch its read bit, write bit, address and write line into the output registers.
  - Set `gnt_id` to the winner and go to BUSY.
- IDLE with no requesting channel: stay in IDLE. `mmu_done` is ignored.
- BUSY:
  - The downstream outputs are driven from the latches and held stable.
  - Requester inputs are ignored, including changes on the owner's own lines.
- BUSY with `mmu_done` high:
  - `l1_done[gnt_id]` is driven high combinationally in the same cycle.
  - `l1_read_data` = `mmu_read_data`, passed straight through.
  - Next state is IDLE. The read and write bits clear at that edge.
- Requester contract: deassert the request at the edge where `l1_done` is sampled high, or keep it asserted to issue a new transaction.
- Read and write both high on the winning channel: both bits are forwarded unchanged. This is a protocol error; the arbiter does not check it.
- `l1_read_data` = `mmu_read_data` at all times. Consumers qualify it with `l1_done`.
- Reset:
  - State goes to IDLE.
  - `mmu_req_read`, `mmu_req_write`, `busy`, `l1_done` = 0.
  - `mmu_req_addr`, `mmu_write_data` = 0; `gnt_id` = 0.
  - Round-robin pointer = N_CH-1.
- Reset asserted mid-BUSY:
  - The downstream request drops immediately (asynchronously).
  - No `l1_done` is emitted.
  - The in-flight transaction is abandoned.

## Timing
- A request sampled at edge E drives `mmu_req_*` and `busy` from E.
- `l1_done` has zero-cycle latency from `mmu_done`.
- Back-to-back transactions are separated by exactly one IDLE cycle. The earliest next downstream request follows the edge after `mmu_done`.
- Minimum transaction length: 2 cycles (grant edge, then `mmu_done` in the following cycle).

## Configuration
- `L1ARB_ROUND_ROBIN_EN` defined:
  - Round-robin selection: the search starts at pointer+1 modulo N_CH.
  - The pointer updates to the winner on every grant.
- Not defined:
  - Fixed priority: the lowest index wins (channel 0, the iCache, highest).
  - The pointer register is not built.
  - This matches the legacy top-level mux behaviour.

## Test plan
- Single read, N_CH=2:
  - Stimulus: ch1 read at addr 0x0000_1040; `mmu_done` 3 cycles after grant with data {8{32'hA5A5_0001}}.
  - Expected: `mmu_req_addr`=0x0000_1040 from the grant edge; `l1_done`=2'b10 for exactly one cycle carrying that data; `busy` low the next cycle.
- Round-robin (macro defined), N_CH=3:
  - Stimulus: all channels request continuously; `mmu_done` 2 cycles after each grant.
  - Expected: grant order 0,1,2,0,1; one idle cycle between grants.
- Fixed priority (macro undefined):
  - Stimulus: ch0 and ch1 request continuously.
  - Expected: grants 0,0,0; ch1 is served only after ch0 deasserts.
- Write latching:
  - Stimulus: ch2 write, addr 0x8000_0020, data {8{32'hDEAD_BEEF}}; requester changes its addr and data during BUSY.
  - Expected: `mmu_req_addr` and `mmu_write_data` keep the latched values until `mmu_done`.
- Reset mid-BUSY:
  - Stimulus: assert `rst` one cycle after a grant.
  - Expected: `mmu_req_read`=0 and `busy`=0 before the next edge; no `l1_done`; after release, ch0 wins first under round-robin.
- Spurious `mmu_done`:
  - Stimulus: `mmu_done`=1 in IDLE.
  - Expected: `l1_done`=0, state unchanged.
